// File: rtl/uart_port_pkg.sv
// Shared definitions for the uart_port peripheral: instruction funct codes, write-back select,
// FSM state encodings and a counter-width helper.
package uart_port_pkg;

  localparam logic [5:0] FUNCT_UART_TX = 6'b111001;
  localparam logic [5:0] FUNCT_UART_RX = 6'b111101;
  localparam logic [1:0] MEMTOREG_UART = 2'b11;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // A divide-by-one counter still needs one bit of storage.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick divider: one-cycle o_tick every DIV clocks.
module uart_baud_gen
  import uart_port_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int unsigned CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_port.sv
// UART peripheral executing uart_tx / uart_rx instructions with pipeline stall.
// Build option: define UART_LOOPBACK_EN to feed the RX synchronizer from the internal TX line.
module uart_port
  import uart_port_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_req,
  input  logic [7:0]  tx_data,
  input  logic        rx_req,
  output logic [31:0] rx_data,
  output logic        stall,
  output logic        rx_overrun,
  output logic        rx_frame_err,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned OSW     = cnt_width(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);

  logic w_tick;

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud (
    .i_clk   (clk),
    .i_reset (reset),
    .o_tick  (w_tick)
  );

  // ---------------------------------------------------------------- transmitter
  tx_state_e      r_tx_state, w_tx_state_next;
  logic [OSW-1:0] r_tx_cnt, w_tx_cnt_next;
  logic [2:0]     r_tx_bit, w_tx_bit_next;
  logic [7:0]     r_tx_shift, w_tx_shift_next;
  logic           r_txd, w_txd_next;
  logic           w_tx_busy, w_tx_last;

  assign w_tx_busy = (r_tx_state != TxIdle);
  assign w_tx_last = (r_tx_cnt == OS_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= TxIdle;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_bit   <= w_tx_bit_next;
      r_tx_shift <= w_tx_shift_next;
      r_txd      <= w_txd_next;
    end
  end

  // The line is re-registered on each tick, so it changes on the first tick after acceptance.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt;
    w_tx_bit_next   = r_tx_bit;
    w_tx_shift_next = r_tx_shift;
    w_txd_next      = r_txd;
    if (w_tx_busy && w_tick) begin
      w_tx_cnt_next = w_tx_last ? '0 : r_tx_cnt + OSW'(1);
    end
    unique case (r_tx_state)
      TxIdle: begin
        w_txd_next = 1'b1;
        if (tx_req) begin
          w_tx_shift_next = tx_data;
          w_tx_cnt_next   = '0;
          w_tx_bit_next   = '0;
          w_tx_state_next = TxStart;
        end
      end
      TxStart: begin
        if (w_tick) begin
          w_txd_next = 1'b0;
          if (w_tx_last) w_tx_state_next = TxData;
        end
      end
      TxData: begin
        if (w_tick) begin
          w_txd_next = r_tx_shift[r_tx_bit];
          if (w_tx_last) begin
            w_tx_bit_next = r_tx_bit + 3'd1;
            if (r_tx_bit == 3'd7) w_tx_state_next = TxStop;
          end
        end
      end
      TxStop: begin
        if (w_tick) begin
          w_txd_next = 1'b1;
          if (w_tx_last) w_tx_state_next = TxIdle;
        end
      end
      default: w_tx_state_next = TxIdle;
    endcase
  end

  assign uart_txd = r_txd;

  // ---------------------------------------------------------------- receiver
  logic w_rx_in;
`ifdef UART_LOOPBACK_EN
  assign w_rx_in = r_txd;
`else
  assign w_rx_in = uart_rxd;
`endif

  logic r_rx_sync1, r_rx_sync2, r_rx_prev;
  logic w_rx_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_prev  <= 1'b1;
    end else begin
      r_rx_sync1 <= w_rx_in;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_prev  <= r_rx_sync2;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_sync2;

  rx_state_e      r_rx_state, w_rx_state_next;
  logic [OSW-1:0] r_rx_cnt, w_rx_cnt_next;
  logic [2:0]     r_rx_bit, w_rx_bit_next;
  logic [7:0]     r_rx_shift, w_rx_shift_next;
  logic           w_rx_deliver, w_rx_ferr_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= RxIdle;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_next;
      r_rx_cnt   <= w_rx_cnt_next;
      r_rx_bit   <= w_rx_bit_next;
      r_rx_shift <= w_rx_shift_next;
    end
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_cnt_next   = r_rx_cnt;
    w_rx_bit_next   = r_rx_bit;
    w_rx_shift_next = r_rx_shift;
    w_rx_deliver    = 1'b0;
    w_rx_ferr_set   = 1'b0;
    unique case (r_rx_state)
      RxIdle: begin
        if (w_rx_fall) begin
          w_rx_cnt_next   = '0;
          w_rx_bit_next   = '0;
          w_rx_state_next = RxStart;
        end
      end
      RxStart: begin
        if (w_tick) begin
          if (r_rx_cnt == OS_HALF) begin
            w_rx_cnt_next   = '0;
            w_rx_state_next = r_rx_sync2 ? RxIdle : RxData;
          end else begin
            w_rx_cnt_next = r_rx_cnt + OSW'(1);
          end
        end
      end
      RxData: begin
        if (w_tick) begin
          if (r_rx_cnt == OS_LAST) begin
            w_rx_cnt_next   = '0;
            w_rx_shift_next = {r_rx_sync2, r_rx_shift[7:1]};
            w_rx_bit_next   = r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) w_rx_state_next = RxStop;
          end else begin
            w_rx_cnt_next = r_rx_cnt + OSW'(1);
          end
        end
      end
      RxStop: begin
        if (w_tick) begin
          if (r_rx_cnt == OS_LAST) begin
            w_rx_cnt_next   = '0;
            w_rx_state_next = RxIdle;
            w_rx_deliver    = r_rx_sync2;
            w_rx_ferr_set   = ~r_rx_sync2;
          end else begin
            w_rx_cnt_next = r_rx_cnt + OSW'(1);
          end
        end
      end
      default: w_rx_state_next = RxIdle;
    endcase
  end

  // ---------------------------------------------------------------- holding register
  logic [7:0] r_rx_hold;
  logic       r_rx_valid, r_rx_overrun, r_rx_frame_err;
  logic       w_rx_consume;

  assign w_rx_consume = rx_req & r_rx_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_hold      <= '0;
      r_rx_valid     <= 1'b0;
      r_rx_overrun   <= 1'b0;
      r_rx_frame_err <= 1'b0;
    end else begin
      if (w_rx_deliver) begin
        // A same-cycle read frees the slot, so the new byte is kept instead of dropped.
        if (r_rx_valid && !w_rx_consume) begin
          r_rx_overrun <= 1'b1;
        end else begin
          r_rx_hold  <= r_rx_shift;
          r_rx_valid <= 1'b1;
        end
      end else if (w_rx_consume) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_ferr_set) r_rx_frame_err <= 1'b1;
    end
  end

  assign rx_data      = {24'h0, r_rx_hold};
  assign rx_overrun   = r_rx_overrun;
  assign rx_frame_err = r_rx_frame_err;
  assign stall        = (tx_req & w_tx_busy) | (rx_req & ~r_rx_valid);

endmodule

// File: tb/tb_uart_port.sv
// Self-checking bench for uart_port: timeline model of the TX line and stall, byte-level RX model.
module tb_uart_port;

  localparam int unsigned CLK_FREQ   = 1_600_000;
  localparam int unsigned BAUD_RATE  = 100_000;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int BITC = 16;

  logic        clk = 1'b0;
  logic        reset, tx_req, rx_req, uart_rxd;
  logic [7:0]  tx_data;
  logic [31:0] rx_data;
  logic        stall, rx_overrun, rx_frame_err, uart_txd;

  uart_port #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_req       (tx_req),
    .tx_data      (tx_data),
    .rx_req       (rx_req),
    .rx_data      (rx_data),
    .stall        (stall),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .uart_txd     (uart_txd),
    .uart_rxd     (uart_rxd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // TX model: a frame accepted with its first START cycle at m_tx_a drives start on
  // offsets 1..16, data bit i on 17+16i..32+16i, and is busy for cycles a..a+159.
  bit         m_tx_act = 1'b0;
  int         m_tx_a = 0;
  logic [7:0] m_tx_byte = '0;
  int         m_tx_accepts = 0;

  function automatic logic exp_txd(input int c);
    int off;
    if (!m_tx_act) return 1'b1;
    off = c - m_tx_a;
    if (off >= 1 && off <= 16) return 1'b0;
    if (off >= 17 && off <= 144) return m_tx_byte[(off - 17) / 16];
    return 1'b1;
  endfunction

  function automatic bit tx_busy(input int c);
    return m_tx_act && (c >= m_tx_a) && (c <= m_tx_a + 159);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      m_tx_act = 1'b0;
    end else begin
      check("txd", uart_txd, exp_txd(cyc));
      if (!rx_req) check("tx_stall", stall, tx_req && tx_busy(cyc));
      if (tx_req && !tx_busy(cyc)) begin
        m_tx_act  = 1'b1;
        m_tx_a    = cyc + 1;
        m_tx_byte = tx_data;
        m_tx_accepts++;
      end
    end
  end

  // RX byte-level model
  bit         m_valid = 1'b0;
  bit         m_ovr   = 1'b0;
  bit         m_ferr  = 1'b0;
  logic [7:0] m_byte  = '0;

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_tx(input logic [7:0] b, output int n_stall);
    int start = m_tx_accepts;
    int k = 0;
    n_stall = 0;
    tx_data = b;
    tx_req  = 1'b1;
    #1;
    while (m_tx_accepts == start && k < 400) begin
      if (stall) n_stall++;
      @(posedge clk);
      #1;
      k++;
    end
    tx_req = 1'b0;
    check("tx_accept_in_time", k < 400, 1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    cycles(BITC);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      cycles(BITC);
    end
    uart_rxd = stop_bit;
    cycles(BITC);
    uart_rxd = 1'b1;
    cycles(4);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_bit);
    if (!stop_bit) m_ferr = 1'b1;
    else if (m_valid) m_ovr = 1'b1;
    else begin
      m_valid = 1'b1;
      m_byte  = b;
    end
  endtask

  task automatic check_flags();
    check("rx_overrun", rx_overrun, m_ovr);
    check("rx_frame_err", rx_frame_err, m_ferr);
  endtask

  task automatic read_rx(input logic [7:0] exp, input int bound, output int waited);
    rx_req = 1'b1;
    waited = 0;
    #1;
    while (stall && waited < bound) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("rx_read_in_time", waited < bound, 1);
    check("rx_data_lit", rx_data, {24'h0, exp});
    @(posedge clk);
    #1;
    rx_req = 1'b0;
  endtask

  task automatic read_model();
    rx_req = 1'b1;
    #1;
    if (m_valid) begin
      check("rx_stall_ready", stall, 0);
      check("rx_data_model", rx_data, {24'h0, m_byte});
    end else begin
      check("rx_stall_empty", stall, 1);
    end
    @(posedge clk);
    #1;
    rx_req  = 1'b0;
    m_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  logic [9:0] a5_slots = 10'b1101001010;
  int ns, w;

  initial begin
    reset = 1'b1; tx_req = 1'b0; rx_req = 1'b0; tx_data = '0; uart_rxd = 1'b1;
    cycles(5);
    reset = 1'b0;
    #1;
    check("reset_txd", uart_txd, 1);
    check("reset_stall", stall, 0);
    check("reset_rx_data", rx_data, 32'h0);
    check("reset_overrun", rx_overrun, 0);
    check("reset_frame_err", rx_frame_err, 0);
    cycles(3);

    // single TX frame, literal slot-by-slot expectations for 8'hA5
    send_tx(8'hA5, ns);
    check("tx_accept_no_stall", ns, 0);
    for (int s = 0; s < 10; s++) begin
      cycles((s == 0) ? 1 : BITC);
      check("tx_a5_slot", uart_txd, a5_slots[s]);
    end
    cycles(20);

    // back-to-back TX
    send_tx(8'h55, ns);
    send_tx(8'h0F, ns);
    check("tx_b2b_stall_cycles", ns, 160);
    cycles(200);

`ifndef UART_LOOPBACK_EN
    // RX stall until a byte arrives
    fork
      read_rx(8'h3C, 400, w);
      send_frame(8'h3C, 1'b1);
    join
    check("rx_stall_release_window", (w >= 145) && (w <= 163), 1);
    check_flags();

    // overrun keeps the first byte
    send_frame(8'h11, 1'b1); model_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1); model_frame(8'h22, 1'b1);
    check_flags();
    check("overrun_lit", rx_overrun, 1);
    read_rx(8'h11, 4, w);
    m_valid = 1'b0;
    read_model();

    // framing error, then glitch, then a clean frame
    send_frame(8'h7E, 1'b0); model_frame(8'h7E, 1'b0);
    check_flags();
    check("frame_err_lit", rx_frame_err, 1);
    read_model();
    uart_rxd = 1'b0;
    cycles(4);
    uart_rxd = 1'b1;
    cycles(40);
    check_flags();
    read_model();
    send_frame(8'hA7, 1'b1); model_frame(8'hA7, 1'b1);
    check_flags();
    read_model();
`endif

    // reset in the middle of a TX frame
    send_tx(8'h96, ns);
    cycles(50);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    #1;
    check("midreset_txd", uart_txd, 1);
    check("midreset_stall", stall, 0);
    check("midreset_rx_data", rx_data, 32'h0);
    check("midreset_overrun", rx_overrun, 0);
    check("midreset_frame_err", rx_frame_err, 0);
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    cycles(4);

`ifdef UART_LOOPBACK_EN
    send_tx(8'hC3, ns);
    cycles(200);
    read_rx(8'hC3, 4, w);
`else
    // randomized TX and RX traffic
    for (int i = 0; i < 8; i++) begin
      logic [7:0] tb_b, rb_b;
      logic       stop_ok;
      tb_b    = 8'($urandom);
      rb_b    = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      fork
        send_tx(tb_b, ns);
        begin
          cycles($urandom_range(1, 20));
          send_frame(rb_b, stop_ok);
        end
      join
      model_frame(rb_b, stop_ok);
      check_flags();
      if ($urandom_range(0, 1) == 1) read_model();
    end
    read_model();
    cycles(200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
